// File: rtl/layer_sequencer.sv
// Inference scheduler: walks the seven network stages and issues one
// (stage, height, depth, width) tuple per cycle, with drain bubbles between stages.
module layer_sequencer #(
   parameter int unsigned CONV1_D = 8,
   parameter int unsigned CONV1_W = 184,
   parameter int unsigned POOL_W  = 92,
   parameter int unsigned CONV2_D = 16,
   parameter int unsigned CONV2_W = 88,
   parameter int unsigned CONV3_D = 32,
   parameter int unsigned CONV3_W = 84,
   parameter int unsigned FC1_D   = 32,
   parameter int unsigned FC1_W   = 7,
   parameter int unsigned FC2_W   = 5,
   parameter int unsigned DRAIN   = 6
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Start,
   input  logic       Stall,
   output logic [8:0] Compute_stage,
   output logic [3:0] Height,
   output logic [4:0] Depth,
   output logic [8:0] Width,
   output logic       Issue_valid,
   output logic       Busy,
   output logic       Done
);

   localparam int unsigned DW = $clog2(DRAIN + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAINING} state_t;
   typedef enum logic [2:0] {
      ST_CONV1, ST_POOL, ST_CONV2, ST_CONV3, ST_GPOOL, ST_FC1, ST_FC2
   } stage_t;

   state_t          state;
   stage_t          stage;
   stage_t          stage_nx;
   logic [3:0]      h_cnt, h_last, h_nx;
   logic [8:0]      w_cnt, w_last, w_nx;
   logic [4:0]      d_cnt, d_last, d_nx;
   logic [DW-1:0]   drain_cnt;
   logic [8:0]      code;
   logic            stage_end;
   logic            issue;

   always_comb begin
      code     = '0;
      h_last   = '0;
      w_last   = '0;
      d_last   = '0;
      stage_nx = ST_CONV1;
      case (stage)
         ST_CONV1: begin
            code = 9'h040; w_last = 9'(CONV1_W - 1); d_last = 5'(CONV1_D - 1); stage_nx = ST_POOL;
         end
         ST_POOL: begin
            code = 9'h020; w_last = 9'(POOL_W - 1); d_last = 5'(CONV1_D - 1); stage_nx = ST_CONV2;
         end
         ST_CONV2: begin
            code = 9'h010; h_last = 4'(CONV1_D - 1); w_last = 9'(CONV2_W - 1);
            d_last = 5'(CONV2_D - 1); stage_nx = ST_CONV3;
         end
         ST_CONV3: begin
            code = 9'h008; h_last = 4'(CONV2_D - 1); w_last = 9'(CONV3_W - 1);
            d_last = 5'(CONV3_D - 1); stage_nx = ST_GPOOL;
         end
         ST_GPOOL: begin
            code = 9'h004; w_last = 9'(CONV3_W - 1); d_last = 5'(CONV3_D - 1); stage_nx = ST_FC1;
         end
         ST_FC1: begin
            code = 9'h002; w_last = 9'(FC1_W - 1); d_last = 5'(FC1_D - 1); stage_nx = ST_FC2;
         end
         ST_FC2: begin
            code = 9'h001; w_last = 9'(FC2_W - 1);
         end
         default: ;
      endcase
   end

   // Uniform H-innermost nest; stages without an input-channel loop have h_last = 0.
   always_comb begin
      h_nx = h_cnt + 4'd1;
      w_nx = w_cnt;
      d_nx = d_cnt;
      if (h_cnt == h_last) begin
         h_nx = '0;
         w_nx = w_cnt + 9'd1;
         if (w_cnt == w_last) begin
            w_nx = '0;
            d_nx = d_cnt + 5'd1;
         end
      end
   end

   assign stage_end = (h_cnt == h_last) && (w_cnt == w_last) && (d_cnt == d_last);
   assign issue     = !Stall && ((state == RUN) || ((state == IDLE) && Start));

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state         <= IDLE;
         stage         <= ST_CONV1;
         h_cnt         <= '0;
         w_cnt         <= '0;
         d_cnt         <= '0;
         drain_cnt     <= '0;
         Compute_stage <= '0;
         Height        <= '0;
         Depth         <= '0;
         Width         <= '0;
         Issue_valid   <= 1'b0;
         Busy          <= 1'b0;
         Done          <= 1'b0;
      end else begin
         Done          <= 1'b0;
         Compute_stage <= '0;
         Height        <= '0;
         Depth         <= '0;
         Width         <= '0;
         Issue_valid   <= 1'b0;

         case (state)
            IDLE: if (Start) begin
               state <= RUN;
               Busy  <= 1'b1;
            end
            // Leaving at count 1 lets the next stage issue right after DRAIN bubbles;
            // the final stage counts one further so Done lands one cycle after them.
            DRAINING: begin
               drain_cnt <= drain_cnt - DW'(1);
               if (drain_cnt == '0) begin
                  state <= IDLE;
                  stage <= ST_CONV1;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
               end else if ((drain_cnt == DW'(1)) && (stage != ST_FC2)) begin
                  state <= RUN;
                  stage <= stage_nx;
               end
            end
            default: ;
         endcase

         if (issue) begin
            Compute_stage <= code;
            Height        <= h_cnt;
            Depth         <= d_cnt;
            Width         <= w_cnt;
            Issue_valid   <= 1'b1;
            if (stage_end) begin
               state     <= DRAINING;
               drain_cnt <= DW'(DRAIN);
               h_cnt     <= '0;
               w_cnt     <= '0;
               d_cnt     <= '0;
            end else begin
               h_cnt <= h_nx;
               w_cnt <= w_nx;
               d_cnt <= d_nx;
            end
         end
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: expected tuple stream and Done cycles are queued by the
// stimulus thread and checked by an independent negedge monitor.
module tb_layer_sequencer;

   localparam int unsigned P_CONV1_W = 4;
   localparam int unsigned P_POOL_W  = 2;
   localparam int unsigned P_CONV2_W = 3;
   localparam int unsigned P_CONV3_W = 2;
   localparam int unsigned P_DRAIN   = 2;
   localparam int unsigned NONE      = 32'hFFFF_FFFF;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stall = 1'b0;
   logic [8:0] compute_stage;
   logic [3:0] height;
   logic [4:0] depth;
   logic [8:0] width;
   logic       issue_valid, busy, done;

   layer_sequencer #(
      .CONV1_W(P_CONV1_W), .POOL_W(P_POOL_W), .CONV2_W(P_CONV2_W),
      .CONV3_W(P_CONV3_W), .DRAIN(P_DRAIN)
   ) dut (
      .Clk(clk), .Rst(rst), .Start(start), .Stall(stall),
      .Compute_stage(compute_stage), .Height(height), .Depth(depth), .Width(width),
      .Issue_valid(issue_valid), .Busy(busy), .Done(done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [8:0]  code;
      logic [3:0]  h;
      logic [4:0]  d;
      logic [8:0]  w;
      int unsigned cyc;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned done_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
      end
   endtask

   // Hand-written network shape: per stage code, H count, W count, D count.
   task automatic dims(input int s, output logic [8:0] code, output int unsigned hn,
                       output int unsigned wn, output int unsigned dn);
      case (s)
         0: begin code = 9'h040; hn = 1;  wn = P_CONV1_W; dn = 8;  end
         1: begin code = 9'h020; hn = 1;  wn = P_POOL_W;  dn = 8;  end
         2: begin code = 9'h010; hn = 8;  wn = P_CONV2_W; dn = 16; end
         3: begin code = 9'h008; hn = 16; wn = P_CONV3_W; dn = 32; end
         4: begin code = 9'h004; hn = 1;  wn = P_CONV3_W; dn = 32; end
         5: begin code = 9'h002; hn = 1;  wn = 7;         dn = 32; end
         default: begin code = 9'h001; hn = 1; wn = 5; dn = 1; end
      endcase
   endtask

   // Queue every tuple (and the Done cycle) expected from a Start in cycle t, with an
   // optional stall of stall_len cycles just before tuple stall_idx; drop anything after stop.
   task automatic gen_run(input int unsigned t, input int unsigned stall_idx,
                          input int unsigned stall_len, input int unsigned stop);
      int unsigned c = t + 1;
      int unsigned idx = 0;
      logic [8:0] code;
      int unsigned hn, wn, dn;
      exp_t e;
      for (int s = 0; s < 7; s++) begin
         dims(s, code, hn, wn, dn);
         for (int unsigned d = 0; d < dn; d++)
            for (int unsigned w = 0; w < wn; w++)
               for (int unsigned h = 0; h < hn; h++) begin
                  if (idx == stall_idx) c += stall_len;
                  if (c <= stop) begin
                     e.code = code; e.h = 4'(h); e.d = 5'(d); e.w = 9'(w); e.cyc = c;
                     exp_q.push_back(e);
                  end
                  c++;
                  idx++;
               end
         c += P_DRAIN;
      end
      if (c <= stop) done_q.push_back(c);
   endtask

   // Monitor: pops an expectation whenever the DUT presents a tuple or Done.
   always @(negedge clk) begin
      exp_t e;
      chk("valid_vs_stage", {63'd0, issue_valid}, {63'd0, compute_stage != 9'd0});
      if (issue_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_tuple", {37'd0, compute_stage, height, depth, width}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("tuple", {37'd0, compute_stage, height, depth, width},
                {37'd0, e.code, e.h, e.d, e.w});
            chk("tuple_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      if (done) begin
         if (done_q.size() == 0) chk("unexpected_done", 64'(cyc), 64'd0);
         else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
   end

   task automatic wait_cyc(input int unsigned n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic chk_tuple(input string name, input logic [26:0] expv);
      chk(name, {37'd0, compute_stage, height, depth, width}, {37'd0, expv});
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", {35'd0, compute_stage, height, depth, width, issue_valid, busy, done}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Run 1: clean run, Start re-pulsed while busy, Stall held during a drain
      t = cyc;
      gen_run(t, NONE, 0, NONE);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(t + 1);
      chk("busy_first", {63'd0, busy}, 64'd1);
      chk_tuple("first_tuple", {9'h040, 4'd0, 5'd0, 9'd0});
      wait_cyc(t + 2);
      chk_tuple("second_tuple", {9'h040, 4'd0, 5'd0, 9'd1});
      wait_cyc(t + 32);
      chk_tuple("conv1_last", {9'h040, 4'd0, 5'd7, 9'd3});
      stall = 1'b1;
      wait_cyc(t + 33);
      chk_tuple("drain_bubble1", 27'd0);
      wait_cyc(t + 34);
      chk_tuple("drain_bubble2", 27'd0);
      stall = 1'b0;
      wait_cyc(t + 35);
      chk_tuple("pool_first", {9'h020, 4'd0, 5'd0, 9'd0});
      wait_cyc(t + 76);
      chk_tuple("conv2_h7_w2", {9'h010, 4'd7, 5'd0, 9'd2});
      wait_cyc(t + 77);
      chk_tuple("conv2_next_d", {9'h010, 4'd0, 5'd1, 9'd0});
      wait_cyc(t + 100);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(t + 1761);
      chk_tuple("last_fc2", {9'h001, 4'd0, 5'd0, 9'd4});
      wait_cyc(t + 1763);
      chk("busy_before_done", {63'd0, busy}, 64'd1);
      wait_cyc(t + 1764);
      chk("done_pulse", {62'd0, busy, done}, 64'd1);
      wait_cyc(t + 1766);
      chk("run1_tuples_left", 64'(exp_q.size()), 64'd0);
      chk("run1_done_left", 64'(done_q.size()), 64'd0);

      // Run 2: three-cycle stall before tuple 532 (mid CONV1D_3rd)
      t = cyc;
      gen_run(t, 532, 3, NONE);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(t + 538);
      stall = 1'b1;
      wait_cyc(t + 540);
      chk_tuple("stall_bubble", 27'd0);
      wait_cyc(t + 541);
      stall = 1'b0;
      wait_cyc(t + 542);
      chk("after_stall_valid", {63'd0, issue_valid}, 64'd1);
      wait_cyc(t + 1767);
      chk("stall_done", {62'd0, busy, done}, 64'd1);
      wait_cyc(t + 1769);
      chk("run2_tuples_left", 64'(exp_q.size()), 64'd0);
      chk("run2_done_left", 64'(done_q.size()), 64'd0);

      // Run 3: asynchronous reset mid FC_1st
      t = cyc;
      gen_run(t, NONE, 0, t + 1611);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(t + 1611);
      chk("fc1_busy", {63'd0, busy}, 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_reset", {35'd0, compute_stage, height, depth, width, issue_valid, busy, done}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_idle", {63'd0, busy}, 64'd0);
      chk("run3_tuples_left", 64'(exp_q.size()), 64'd0);

      // Run 4: fresh start after reset
      t = cyc;
      gen_run(t, NONE, 0, NONE);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(t + 1);
      chk_tuple("restart_first", {9'h040, 4'd0, 5'd0, 9'd0});
      wait_cyc(t + 1767);
      chk("run4_tuples_left", 64'(exp_q.size()), 64'd0);
      chk("run4_done_left", 64'(done_q.size()), 64'd0);
      chk("final_idle", {63'd0, busy}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
